// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input conditioner: pad bit layout,
// coin FSM states and the helper that pulls one player's word off the packed bus.
package arcade_input_pkg;

  localparam int JB_RIGHT  = 0;
  localparam int JB_LEFT   = 1;
  localparam int JB_DOWN   = 2;
  localparam int JB_UP     = 3;
  localparam int JB_FIRE   = 4;
  localparam int JB_START  = 5;
  localparam int JB_START2 = 6;
  localparam int JB_COIN   = 7;
  localparam int JB_PAUSE  = 8;

  localparam int PAD_BITS = JB_PAUSE + 1;
  // Widest packed bus supported: 4 players of up to 32 bits each.
  localparam int BUS_MAX  = 128;

  typedef logic [PAD_BITS-1:0] pad_t;

  typedef enum logic [1:0] {
    COIN_IDLE  = 2'd0,
    COIN_PULSE = 2'd1,
    COIN_GAP   = 2'd2
  } coin_state_e;

  function automatic pad_t pad_slice(input logic [BUS_MAX-1:0] bus,
                                     input int unsigned k,
                                     input int unsigned w);
    return pad_t'(bus >> (k * w));
  endfunction

endpackage

// File: rtl/arcade_input_ctrl_coin_pulser.sv
// One coin channel: a saturating 2-bit queue of coin edges drained into
// fixed-length pulses separated by a minimum low gap, both timed in ticks.
module coin_pulser
  import arcade_input_pkg::*;
#(
  parameter int COIN_TICKS     = 50,
  parameter int COIN_GAP_TICKS = 50
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic tick_i,
  input  logic edge_i,
  output logic coin_o
);

  localparam int GAP_LOAD = COIN_GAP_TICKS + 1;
  localparam int CNT_MAX  = (COIN_TICKS > GAP_LOAD) ? COIN_TICKS : GAP_LOAD;
  localparam int CW       = $clog2(CNT_MAX + 1);

  coin_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    pend_q, pend_d;
  logic          coin_q, coin_d;
  logic          take;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    take    = 1'b0;
    case (state_q)
      COIN_IDLE: begin
        if (pend_q != 2'd0) begin
          state_d = COIN_PULSE;
          cnt_d   = CW'(COIN_TICKS);
          take    = 1'b1;
        end
      end
      COIN_PULSE: begin
        if (cnt_q == '0) begin
          state_d = COIN_GAP;
          // One extra tick so the gap never falls short, whatever the tick phase.
          cnt_d   = CW'(GAP_LOAD);
        end else if (tick_i) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      COIN_GAP: begin
        if (cnt_q == '0) begin
          state_d = COIN_IDLE;
        end else if (tick_i) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = COIN_IDLE;
    endcase

    if (edge_i && !take && pend_q != 2'd3) begin
      pend_d = pend_q + 2'd1;
    end else if (!edge_i && take) begin
      pend_d = pend_q - 2'd1;
    end
    coin_d = (state_d == COIN_PULSE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= COIN_IDLE;
      cnt_q   <= '0;
      pend_q  <= 2'd0;
      coin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      coin_q  <= coin_d;
    end
  end

  assign coin_o = coin_q;

endmodule

// File: rtl/arcade_input_ctrl.sv
// Player-input conditioner: routes hps_io pads to player channels (swap/shared),
// registers directions/start, shapes coin pulses, adds autofire and a pause toggle.
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS    = 2,
  parameter int JOY_W          = 16,
  parameter int TICK_DIV       = 12000,
  parameter int COIN_TICKS     = 50,
  parameter int COIN_GAP_TICKS = 50,
  parameter int AUTOFIRE_TICKS = 33
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic [NUM_PLAYERS*JOY_W-1:0] joystick,
  input  logic                       cfg_shared,
  input  logic                       cfg_swap,
  input  logic                       cfg_autofire,
  output logic [NUM_PLAYERS*4-1:0]   p_dir,
  output logic [NUM_PLAYERS-1:0]     p_fire,
  output logic [NUM_PLAYERS-1:0]     p_start,
  output logic [NUM_PLAYERS-1:0]     p_coin,
  output logic                       pause
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int AW = $clog2(AUTOFIRE_TICKS + 1);

  logic [TW-1:0] div_q;
  logic          tick;

  assign tick = (div_q == TW'(TICK_DIV - 1));

  always_ff @(posedge clk_sys) begin
    if (reset) div_q <= '0;
    else       div_q <= tick ? '0 : div_q + TW'(1);
  end

  logic [BUS_MAX-1:0] joy_ext;
  pad_t               raw [NUM_PLAYERS];
  pad_t               src [NUM_PLAYERS];
  pad_t               shared_pad;
  logic               pause_raw;

  assign joy_ext = BUS_MAX'(joystick);

  always_comb begin
    shared_pad = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) shared_pad |= raw[k];
  end
  assign pause_raw = shared_pad[JB_PAUSE];

  logic [NUM_PLAYERS*4-1:0] p_dir_q, p_dir_d;
  logic [NUM_PLAYERS-1:0]   p_fire_q, p_fire_d, p_start_q, p_start_d;

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
    // Cocktail swap only ever exchanges the first two channels.
    localparam int   SWAP_IDX = (NUM_PLAYERS > 1 && gi < 2) ? 1 - gi : gi;
    localparam logic IS_P1    = (gi == 1);

    logic          fire, coin_prev_q, coin_edge;
    logic          fire_prev_q, phase_q, phase_d;
    logic [AW-1:0] af_cnt_q, af_cnt_d;

    assign raw[gi] = pad_slice(joy_ext, gi, JOY_W);
    assign src[gi] = cfg_shared ? shared_pad : (cfg_swap ? raw[SWAP_IDX] : raw[gi]);

    assign p_dir_d[gi*4 +: 4] = src[gi][JB_UP:JB_RIGHT];
    assign p_start_d[gi]      = src[gi][JB_START] | (IS_P1 & src[0][JB_START2]);

    assign fire      = src[gi][JB_FIRE];
    assign coin_edge = src[gi][JB_COIN] & ~coin_prev_q;

    always_comb begin
      phase_d  = phase_q;
      af_cnt_d = af_cnt_q;
      if (!fire) begin
        phase_d = 1'b0;
      end else if (!fire_prev_q) begin
        phase_d  = 1'b1;
        af_cnt_d = AW'(AUTOFIRE_TICKS);
      end else if (tick) begin
        if (af_cnt_q <= AW'(1)) begin
          phase_d  = ~phase_q;
          af_cnt_d = AW'(AUTOFIRE_TICKS);
        end else begin
          af_cnt_d = af_cnt_q - AW'(1);
        end
      end
    end

    assign p_fire_d[gi] = cfg_autofire ? (fire & phase_d) : fire;

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        coin_prev_q <= 1'b0;
        fire_prev_q <= 1'b0;
        phase_q     <= 1'b0;
        af_cnt_q    <= '0;
      end else begin
        coin_prev_q <= src[gi][JB_COIN];
        fire_prev_q <= fire;
        phase_q     <= phase_d;
        af_cnt_q    <= af_cnt_d;
      end
    end

    coin_pulser #(
      .COIN_TICKS    (COIN_TICKS),
      .COIN_GAP_TICKS(COIN_GAP_TICKS)
    ) u_coin (
      .clk_sys(clk_sys),
      .reset  (reset),
      .tick_i (tick),
      .edge_i (coin_edge),
      .coin_o (p_coin[gi])
    );
  end

  logic pause_prev_q, pause_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      p_dir_q      <= '0;
      p_fire_q     <= '0;
      p_start_q    <= '0;
      pause_prev_q <= 1'b0;
      pause_q      <= 1'b0;
    end else begin
      p_dir_q      <= p_dir_d;
      p_fire_q     <= p_fire_d;
      p_start_q    <= p_start_d;
      pause_prev_q <= pause_raw;
      if (pause_raw && !pause_prev_q) pause_q <= ~pause_q;
    end
  end

  assign p_dir   = p_dir_q;
  assign p_fire  = p_fire_q;
  assign p_start = p_start_q;
  assign pause   = pause_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Scoreboard bench for arcade_input_ctrl: a pad-level reference model feeds
// expectation queues that independent monitors drain against the outputs.
module tb_arcade_input_ctrl;

  localparam int NP = 2;
  localparam int JW = 16;
  localparam int TD = 4;
  localparam int CT = 3;
  localparam int GT = 2;
  localparam int AT = 2;

  logic             clk_sys = 1'b0;
  logic             reset = 1'b1;
  logic [NP*JW-1:0] joystick = '0;
  logic             cfg_shared = 1'b0, cfg_swap = 1'b0, cfg_autofire = 1'b0;
  logic [NP*4-1:0]  p_dir;
  logic [NP-1:0]    p_fire, p_start, p_coin;
  logic             pause;

  always #5 clk_sys = ~clk_sys;

  arcade_input_ctrl #(
    .NUM_PLAYERS(NP), .JOY_W(JW), .TICK_DIV(TD),
    .COIN_TICKS(CT), .COIN_GAP_TICKS(GT), .AUTOFIRE_TICKS(AT)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .joystick(joystick),
    .cfg_shared(cfg_shared), .cfg_swap(cfg_swap), .cfg_autofire(cfg_autofire),
    .p_dir(p_dir), .p_fire(p_fire), .p_start(p_start), .p_coin(p_coin), .pause(pause)
  );

  typedef struct {
    logic [7:0] dir;
    logic [1:0] fire;
    logic [1:0] start;
    logic       pause;
  } exp_t;

  exp_t exp_q[$];
  int   coin_exp_q[$];
  int   n_cmp = 0, n_bad = 0;
  bit   model_pause = 0, model_pause_prev = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference model: derive each player's pad from the routing rules, then outputs.
  task automatic drive(input logic [JW-1:0] j0, input logic [JW-1:0] j1, input bit sh, input bit sw);
    logic [JW-1:0] s0, s1;
    exp_t e;
    bit cur;
    @(negedge clk_sys);
    joystick = {j1, j0};
    cfg_shared = sh;
    cfg_swap = sw;
    cfg_autofire = 1'b0;
    if (sh) begin s0 = j0 | j1; s1 = j0 | j1; end
    else if (sw) begin s0 = j1; s1 = j0; end
    else begin s0 = j0; s1 = j1; end
    e.dir   = {s1[3:0], s0[3:0]};
    e.fire  = {s1[4], s0[4]};
    e.start = {s1[5] | s0[6], s0[5]};
    cur = j0[8] | j1[8];
    if (cur && !model_pause_prev) model_pause = ~model_pause;
    model_pause_prev = cur;
    e.pause = model_pause;
    exp_q.push_back(e);
    $display("drive j0=%04h j1=%04h shared=%0d swap=%0d", j0, j1, sh, sw);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1;
    joystick = '0;
    cfg_shared = 0; cfg_swap = 0; cfg_autofire = 0;
    coin_exp_q.delete();
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    model_pause = 0;
    model_pause_prev = 0;
  endtask

  task automatic settle();
    @(posedge clk_sys);
    #2;
  endtask

  // Monitor: pops per-cycle expectations and measures coin pulses on channel 0.
  int cyc = 0, last_fall = -1, rise_cyc = 0;
  bit coin_prev = 0;
  always @(posedge clk_sys) begin
    exp_t e;
    int w;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("p_dir", p_dir, e.dir);
      check("p_fire", p_fire, e.fire);
      check("p_start", p_start, e.start);
      check("pause", pause, e.pause);
    end
    if (reset) begin
      coin_prev = 0;
      last_fall = -1;
    end else begin
      if (p_coin[0] && !coin_prev) begin
        rise_cyc = cyc;
        if (last_fall >= 0) check("coin_gap_min", (cyc - last_fall) >= GT * TD, 1);
      end
      if (!p_coin[0] && coin_prev) begin
        last_fall = cyc;
        check("coin_pulse_expected", coin_exp_q.size() > 0, 1);
        if (coin_exp_q.size() > 0) begin
          w = coin_exp_q.pop_front();
          check("coin_width", ((cyc - rise_cyc) >= (w - 1) * TD) && ((cyc - rise_cyc) <= (w + 1) * TD), 1);
          $display("coin pulse width=%0d cycles", cyc - rise_cyc);
        end
      end
      coin_prev = p_coin[0];
    end
  end

  task automatic test_coin_queue();
    int n_edges;
    do_reset();
    n_edges = 5;
    // Every edge lands while the first pulse is still high: one in service, up to three queued.
    for (int i = 0; i < 1 + ((n_edges - 1 < 3) ? n_edges - 1 : 3); i++) coin_exp_q.push_back(CT);
    for (int i = 0; i < 2 * n_edges; i++) begin
      @(negedge clk_sys);
      if (i == 1) check("coin_latency_early", p_coin[0], 0);
      if (i == 2) check("coin_latency", p_coin[0], 1);
      joystick[7] = (i % 2 == 0);
    end
    @(negedge clk_sys) joystick[7] = 1'b0;
    repeat (160) @(posedge clk_sys);
    #2;
    check("coin_queue_drained", coin_exp_q.size(), 0);
    check("coin_p1_idle", p_coin[1], 0);
  endtask

  task automatic test_coin_reset();
    int w, highs;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys);
      joystick[7] = (i % 2 == 0);
    end
    @(negedge clk_sys) joystick[7] = 1'b0;
    w = 0;
    while (!p_coin[0] && w < 30) begin
      @(posedge clk_sys); #1; w++;
    end
    check("coin_before_reset", p_coin[0], 1);
    @(negedge clk_sys) reset = 1'b1;
    @(posedge clk_sys); #2;
    check("coin_drop_on_reset", p_coin, 0);
    check("dir_on_reset", p_dir, 0);
    @(negedge clk_sys) reset = 1'b0;
    highs = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk_sys); #2;
      if (p_coin != 0) highs++;
    end
    check("coin_after_reset", highs, 0);
  endtask

  task automatic test_autofire();
    bit s[40];
    int run, nrun;
    do_reset();
    @(negedge clk_sys);
    cfg_autofire = 1'b1;
    joystick[4] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_sys); #2;
      s[i] = p_fire[0];
    end
    check("af_first_shot", s[0], 1);
    run = 1;
    nrun = 0;
    for (int i = 1; i < 40; i++) begin
      if (s[i] == s[i-1]) run++;
      else begin
        if (nrun == 0) check("af_first_run", (run >= (AT - 1) * TD + 1) && (run <= AT * TD), 1);
        else check("af_half_period", run, AT * TD);
        nrun++;
        run = 1;
      end
    end
    check("af_toggles", nrun >= 3, 1);
    @(negedge clk_sys) joystick[4] = 1'b0;
    @(posedge clk_sys); #2;
    check("af_release", p_fire[0], 0);
  endtask

  initial begin
    repeat (2) @(negedge clk_sys);
    check("reset_dir", p_dir, 0);
    check("reset_fire", p_fire, 0);
    check("reset_start", p_start, 0);
    check("reset_coin", p_coin, 0);
    check("reset_pause", pause, 0);
    reset = 1'b0;

    for (int i = 0; i < 300; i++)
      drive(JW'($urandom) & ~JW'(16'h0080), JW'($urandom) & ~JW'(16'h0080),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
    settle();

    do_reset();
    drive(16'h0001, 16'h0008, 0, 0); settle(); check("route_plain", p_dir, 8'b1000_0001);
    drive(16'h0001, 16'h0008, 0, 1); settle(); check("route_swap", p_dir, 8'b0001_1000);
    drive(16'h0001, 16'h0008, 1, 1); settle(); check("route_shared", p_dir, 8'b1001_1001);
    drive(16'h0040, 16'h0000, 0, 0); settle(); check("start_2p", p_start, 2'b10);
    drive(16'h0000, 16'h0020, 0, 1); settle(); check("start_swap", p_start, 2'b01);
    drive(16'h0000, 16'h0100, 0, 0); settle(); check("pause_on", pause, 1);
    drive(16'h0000, 16'h0000, 0, 0); settle();
    drive(16'h0000, 16'h0100, 0, 0); settle(); check("pause_off", pause, 0);
    for (int i = 0; i < 5; i++) drive(16'h0000, 16'h0100, 0, 0);
    settle(); check("pause_held", pause, 0);
    drive(16'h0000, 16'h0000, 0, 0);
    for (int i = 0; i < 5; i++) drive(16'h0100, 16'h0000, 0, 0);
    settle(); check("pause_held_single", pause, 1);

    test_coin_queue();
    test_coin_reset();
    test_autofire();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
